// File: rtl/acl_mode_sequencer.sv
// Tester sequencer for the PMOD ACL2 driver: one-hot mode selection, init/start
// command handshakes, run hold and soft reset. Optional watchdog: ACL_SEQ_WATCHDOG_EN.
module acl_mode_sequencer #(
  parameter int unsigned MODE_COUNT     = 2,
  parameter int unsigned SWITCH_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  localparam int unsigned IdxW          = (MODE_COUNT > 1) ? $clog2(MODE_COUNT) : 1
) (
  input  logic                    i_clk_20mhz,
  input  logic                    i_rstn_20mhz,
  input  logic                    i_acl_command_ready,
  input  logic [SWITCH_WIDTH-1:0] i_switches_debounced,
  output logic [MODE_COUNT-1:0]   o_acl_cmd_init,
  output logic [MODE_COUNT-1:0]   o_acl_cmd_start,
  output logic                    o_acl_cmd_soft_reset,
  output logic [MODE_COUNT-1:0]   o_mode_active,
  output logic [IdxW-1:0]         o_mode_index,
  output logic                    o_reading_inactive,
  output logic                    o_active_init_display,
  output logic                    o_active_run_display,
  output logic                    o_fault
);

  localparam int unsigned CntW = $clog2(SWITCH_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT_REQ,
    INIT_WAIT,
    START_REQ,
    START_DONE,
    RUN,
    RESET_REQ,
    FAULT
  } state_e;

  state_e                state_q, state_d;
  logic [MODE_COUNT-1:0] mode_active_q, mode_active_d;
  logic [IdxW-1:0]       mode_index_q, mode_index_d;

  logic [CntW-1:0]       sel_total_c;
  logic [CntW-1:0]       sel_in_range_c;
  logic [IdxW-1:0]       sel_idx_c;
  logic                  sel_valid_c;
  logic                  switches_clear_c;
  logic                  wd_expired_c;

  // Valid selection: exactly one switch set overall, and that one is a mode switch.
  always_comb begin
    sel_total_c    = '0;
    sel_in_range_c = '0;
    sel_idx_c      = '0;
    for (int i = 0; i < int'(SWITCH_WIDTH); i++) begin
      if (i_switches_debounced[i]) begin
        sel_total_c = sel_total_c + CntW'(1);
        if (i < int'(MODE_COUNT)) begin
          sel_in_range_c = sel_in_range_c + CntW'(1);
          sel_idx_c      = IdxW'(i);
        end
      end
    end
    sel_valid_c      = (sel_total_c == CntW'(1)) && (sel_in_range_c == CntW'(1));
    switches_clear_c = (i_switches_debounced == '0);
  end

`ifdef ACL_SEQ_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_watch_c;
  logic           fault_q, fault_d;

  // Counter runs only while waiting on a driver handshake; any state change restarts it.
  always_comb begin
    wd_watch_c = (state_q == INIT_REQ) || (state_q == INIT_WAIT) ||
                 (state_q == START_REQ) || (state_q == RESET_REQ);
    wd_expired_c = wd_watch_c && (wd_cnt_q == WdW'(TIMEOUT_CYCLES));
    wd_cnt_d = wd_cnt_q;
    if (state_d != state_q) begin
      wd_cnt_d = '0;
    end else if (wd_watch_c && (wd_cnt_q != WdW'(TIMEOUT_CYCLES))) begin
      wd_cnt_d = wd_cnt_q + WdW'(1);
    end
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      wd_cnt_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      fault_q  <= fault_d;
    end
  end

  assign o_fault = fault_q;
`else
  assign wd_expired_c = 1'b0;
  assign o_fault      = 1'b0;
`endif

  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_q       <= IDLE;
      mode_active_q <= '0;
      mode_index_q  <= '0;
    end else begin
      state_q       <= state_d;
      mode_active_q <= mode_active_d;
      mode_index_q  <= mode_index_d;
    end
  end

  // Next state, mode registers and Moore output decode.
  always_comb begin
    state_d               = state_q;
    mode_active_d         = mode_active_q;
    mode_index_d          = mode_index_q;
    o_acl_cmd_init        = '0;
    o_acl_cmd_start       = '0;
    o_acl_cmd_soft_reset  = 1'b0;
    o_reading_inactive    = 1'b0;
    o_active_init_display = 1'b0;
    o_active_run_display  = 1'b0;

    unique case (state_q)
      IDLE: begin
        o_reading_inactive = 1'b1;
        if (i_acl_command_ready && sel_valid_c) begin
          state_d       = INIT_REQ;
          mode_index_d  = sel_idx_c;
          mode_active_d = MODE_COUNT'(1) << sel_idx_c;
        end
      end
      INIT_REQ: begin
        o_acl_cmd_init        = mode_active_q;
        o_active_init_display = 1'b1;
        if (wd_expired_c) begin
          state_d = FAULT;
        end else if (!i_acl_command_ready) begin
          state_d = INIT_WAIT;
        end
      end
      INIT_WAIT: begin
        o_active_init_display = 1'b1;
        if (wd_expired_c) begin
          state_d = FAULT;
        end else if (i_acl_command_ready) begin
          state_d = START_REQ;
        end
      end
      START_REQ: begin
        o_acl_cmd_start       = mode_active_q;
        o_active_init_display = 1'b1;
        if (wd_expired_c) begin
          state_d = FAULT;
        end else if (!i_acl_command_ready) begin
          state_d = START_DONE;
        end
      end
      START_DONE: begin
        o_active_init_display = 1'b1;
        state_d               = RUN;
      end
      RUN: begin
        o_active_run_display = 1'b1;
        if (switches_clear_c) begin
          state_d       = RESET_REQ;
          mode_active_d = '0;
        end
      end
      RESET_REQ: begin
        o_acl_cmd_soft_reset = 1'b1;
        if (wd_expired_c) begin
          state_d = FAULT;
        end else if (i_acl_command_ready) begin
          state_d = IDLE;
        end
      end
      FAULT: begin
        if (switches_clear_c) begin
          state_d       = RESET_REQ;
          mode_active_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_mode_active = mode_active_q;
  assign o_mode_index  = mode_index_q;

endmodule

// File: tb/tb_acl_mode_sequencer.sv
// Directed bench for acl_mode_sequencer with MODE_COUNT=3, SWITCH_WIDTH=4, TIMEOUT_CYCLES=16.
module tb_acl_mode_sequencer;

  localparam int unsigned MC = 3;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ready;
  logic [SW-1:0] sw;
  logic [MC-1:0] cmd_init, cmd_start, mode_active;
  logic [1:0]    mode_index;
  logic          soft_reset, inactive, init_disp, run_disp, fault;

  int n_checks = 0;
  int n_errors = 0;

  acl_mode_sequencer #(
    .MODE_COUNT    (MC),
    .SWITCH_WIDTH  (SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk_20mhz          (clk),
    .i_rstn_20mhz         (rstn),
    .i_acl_command_ready  (ready),
    .i_switches_debounced (sw),
    .o_acl_cmd_init       (cmd_init),
    .o_acl_cmd_start      (cmd_start),
    .o_acl_cmd_soft_reset (soft_reset),
    .o_mode_active        (mode_active),
    .o_mode_index         (mode_index),
    .o_reading_inactive   (inactive),
    .o_active_init_display(init_disp),
    .o_active_run_display (run_disp),
    .o_fault              (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn  = 1'b0;
    ready = 1'b1;
    sw    = 4'b0100;
    step(2);
    check("rst_inactive", 32'(inactive), 32'd1);
    check("rst_init", 32'(cmd_init), 32'd0);
    check("rst_mode_active", 32'(mode_active), 32'd0);
    check("rst_index", 32'(mode_index), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    rstn = 1'b1;
    step(1);
    check("sel_init", 32'(cmd_init), 32'b100);
    check("sel_index", 32'(mode_index), 32'd2);
    check("sel_mode_active", 32'(mode_active), 32'b100);
    check("sel_init_disp", 32'(init_disp), 32'd1);

    ready = 1'b0;
    step(3);
    check("wait_init_off", 32'(cmd_init), 32'd0);
    check("wait_init_disp", 32'(init_disp), 32'd1);
    ready = 1'b1;
    step(1);
    check("start_cmd", 32'(cmd_start), 32'b100);
    ready = 1'b0;
    step(1);
    check("start_done_disp", 32'(init_disp), 32'd1);
    check("start_done_run", 32'(run_disp), 32'd0);
    check("start_done_cmd", 32'(cmd_start), 32'd0);
    step(1);
    check("run_disp", 32'(run_disp), 32'd1);

    sw = 4'b0001;
    step(1);
    sw = 4'b0010;
    step(2);
    check("run_ignore_disp", 32'(run_disp), 32'd1);
    check("run_ignore_mode", 32'(mode_active), 32'b100);

    sw = 4'b0000;
    step(1);
    check("rr_soft_reset", 32'(soft_reset), 32'd1);
    check("rr_mode_cleared", 32'(mode_active), 32'd0);
    step(1);
    check("rr_hold", 32'(soft_reset), 32'd1);
    ready = 1'b1;
    step(1);
    check("rr_to_idle", 32'(inactive), 32'd1);
    check("rr_release", 32'(soft_reset), 32'd0);

    sw = 4'b0011;
    step(3);
    check("two_bits_idle", 32'(inactive), 32'd1);
    check("two_bits_init", 32'(cmd_init), 32'd0);
    sw = 4'b1000;
    step(3);
    check("out_range_idle", 32'(inactive), 32'd1);
    check("out_range_init", 32'(cmd_init), 32'd0);
    ready = 1'b0;
    sw    = 4'b0001;
    step(3);
    check("not_ready_idle", 32'(inactive), 32'd1);

    ready = 1'b1;
    step(1);
    check("mode0_init", 32'(cmd_init), 32'b001);
    check("mode0_index", 32'(mode_index), 32'd0);
    step(14);
    check("wd_early_fault", 32'(fault), 32'd0);
`ifdef ACL_SEQ_WATCHDOG_EN
    begin
      int budget = 10;
      while (!fault && budget > 0) begin
        step(1);
        budget--;
      end
    end
    check("wd_fault", 32'(fault), 32'd1);
    check("wd_fault_init", 32'(cmd_init), 32'd0);
    check("wd_fault_inactive", 32'(inactive), 32'd0);
    sw = 4'b0000;
    step(1);
    check("wd_clear_fault", 32'(fault), 32'd0);
    check("wd_soft_reset", 32'(soft_reset), 32'd1);
    step(1);
    check("wd_back_idle", 32'(inactive), 32'd1);
    sw = 4'b0010;
    step(1);
    ready = 1'b0;
    step(1);
    ready = 1'b1;
    step(1);
    check("pre_rst_start", 32'(cmd_start), 32'b010);
`else
    step(100);
    check("nowd_init_held", 32'(cmd_init), 32'b001);
    check("nowd_fault", 32'(fault), 32'd0);
    ready = 1'b0;
    step(1);
    ready = 1'b1;
    step(1);
    check("pre_rst_start", 32'(cmd_start), 32'b001);
`endif

    #2 rstn = 1'b0;
    #1;
    check("async_start", 32'(cmd_start), 32'd0);
    check("async_inactive", 32'(inactive), 32'd1);
    check("async_mode_active", 32'(mode_active), 32'd0);
    check("async_index", 32'(mode_index), 32'd0);
    check("async_fault", 32'(fault), 32'd0);
    check("async_init_disp", 32'(init_disp), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
